// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the single SDRAM controller host port between
// the CPU data master, the CPU instruction master and an auxiliary master
// (JTAG/DMA/video). Fixed priority data > instr > aux, with an anti-starvation
// counter that forces aux to win after STARVE_LIMIT lost arbitrations.
// One controller transaction is in flight at a time; the granted master's
// request fields are captured at grant time and held until the controller acks.
module sdram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8   // 1..255
) (
   input  logic        clk,
   input  logic        reset,

   // CPU data master
   input  logic [19:1] d_m_addr,
   input  logic [15:0] d_m_data_out,
   output logic [15:0] d_m_data_in,
   input  logic        d_m_access,
   input  logic        d_m_wr_en,
   input  logic [1:0]  d_m_bytesel,
   output logic        d_m_ack,

   // CPU instruction master (read-only)
   input  logic [19:1] i_m_addr,
   output logic [15:0] i_m_data_in,
   input  logic        i_m_access,
   output logic        i_m_ack,

   // auxiliary master
   input  logic [19:1] a_m_addr,
   input  logic [15:0] a_m_data_out,
   output logic [15:0] a_m_data_in,
   input  logic        a_m_access,
   input  logic        a_m_wr_en,
   input  logic [1:0]  a_m_bytesel,
   output logic        a_m_ack,

   // SDRAM controller host port
   output logic [19:1] q_m_addr,
   output logic [15:0] q_m_data_out,
   input  logic [15:0] q_m_data_in,
   output logic        q_m_access,
   output logic        q_m_wr_en,
   output logic [1:0]  q_m_bytesel,
   input  logic        q_m_ack,

   output logic [1:0]  grant
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [1:0] G_NONE  = 2'd0;
   localparam logic [1:0] G_DATA  = 2'd1;
   localparam logic [1:0] G_INSTR = 2'd2;
   localparam logic [1:0] G_AUX   = 2'd3;

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   state_t      state;
   // bit 0 data, bit 1 instr, bit 2 aux; set only for the cycle after an ack
   // so a requester that has not yet dropped access is not served twice
   logic [2:0]  served_mask;
   logic [7:0]  starve_cnt;

   logic        req_d;
   logic        req_i;
   logic        req_a;
   logic        any_req;
   logic [1:0]  win;
   logic [19:1] win_addr;
   logic [15:0] win_data;
   logic        win_wr_en;
   logic [1:0]  win_bytesel;

   // Arbitration: masked requests, then starvation override, then fixed priority
   always_comb begin
      req_d   = d_m_access & ~served_mask[0];
      req_i   = i_m_access & ~served_mask[1];
      req_a   = a_m_access & ~served_mask[2];
      any_req = req_d | req_i | req_a;
      win     = G_NONE;
      if (req_a && (starve_cnt == STARVE_MAX)) begin
         win = G_AUX;
      end else if (req_d) begin
         win = G_DATA;
      end else if (req_i) begin
         win = G_INSTR;
      end else if (req_a) begin
         win = G_AUX;
      end
   end

   // Winner's request fields; the instruction side is a fixed full-word read
   always_comb begin
      win_addr    = '0;
      win_data    = '0;
      win_wr_en   = 1'b0;
      win_bytesel = 2'b00;
      case (win)
         G_DATA: begin
            win_addr    = d_m_addr;
            win_data    = d_m_data_out;
            win_wr_en   = d_m_wr_en;
            win_bytesel = d_m_bytesel;
         end
         G_INSTR: begin
            win_addr    = i_m_addr;
            win_data    = '0;
            win_wr_en   = 1'b0;
            win_bytesel = 2'b11;
         end
         G_AUX: begin
            win_addr    = a_m_addr;
            win_data    = a_m_data_out;
            win_wr_en   = a_m_wr_en;
            win_bytesel = a_m_bytesel;
         end
         default: begin
            win_addr    = '0;
            win_data    = '0;
            win_wr_en   = 1'b0;
            win_bytesel = 2'b00;
         end
      endcase
   end

   // Ownership FSM: capture the winner in IDLE, hold the port until the controller acks
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         grant        <= G_NONE;
         q_m_access   <= 1'b0;
         q_m_wr_en    <= 1'b0;
         q_m_bytesel  <= 2'b00;
         q_m_addr     <= '0;
         q_m_data_out <= '0;
         starve_cnt   <= '0;
         served_mask  <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               served_mask <= 3'b000;
               if (any_req) begin
                  state        <= BUSY;
                  grant        <= win;
                  q_m_access   <= 1'b1;
                  q_m_addr     <= win_addr;
                  q_m_data_out <= win_data;
                  q_m_wr_en    <= win_wr_en;
                  q_m_bytesel  <= win_bytesel;
                  if (win == G_AUX) begin
                     starve_cnt <= '0;
                  end else if (req_a && (starve_cnt != STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + 8'd1;
                  end
               end
            end
            BUSY: begin
               if (q_m_ack) begin
                  state       <= IDLE;
                  grant       <= G_NONE;
                  q_m_access  <= 1'b0;
                  served_mask <= {grant == G_AUX, grant == G_INSTR, grant == G_DATA};
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Completion and read data steered to the current owner only
   always_comb begin
      d_m_ack     = q_m_ack & (grant == G_DATA);
      i_m_ack     = q_m_ack & (grant == G_INSTR);
      a_m_ack     = q_m_ack & (grant == G_AUX);
      d_m_data_in = (grant == G_DATA)  ? q_m_data_in : 16'h0000;
      i_m_data_in = (grant == G_INSTR) ? q_m_data_in : 16'h0000;
      a_m_data_in = (grant == G_AUX)   ? q_m_data_in : 16'h0000;
   end

endmodule
